// File: rtl/fifo_ser_pkg.sv
// Shared types and constants for the FIFO frame serializer.
package fifo_ser_pkg;

    // Serializer FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        LATCH = 2'd2,
        SHIFT = 2'd3
    } ser_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int FRAME_W              = 11;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: raises tick on the last cycle of every CLKS_PER_BIT-cycle
// period while enabled; a synchronous clear restarts the period.
module baud_tick_gen
    import fifo_ser_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic rd_clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int                 CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST_CNT);

    // Next count: clear wins, otherwise wrap at the end of each bit period.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_frame_serializer.sv
// Pops words from the read side of a FIFO and shifts each one out LSB-first
// on tx, holding every bit for CLKS_PER_BIT rd_clk cycles.
module fifo_frame_serializer
    import fifo_ser_pkg::*;
#(
    parameter int   DATA_W       = FRAME_W,
    parameter int   CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter logic IDLE_LEVEL   = 1'b1,
    parameter int   CNT_W        = 16
) (
    input  logic              rd_clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frames_sent
);

    localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    ser_state_e        state_q, state_d;
    logic              fifo_rd_q, fifo_rd_d;
    logic              tx_q, tx_d;
    logic              frame_done_q, frame_done_d;
    logic [CNT_W-1:0]  frames_q, frames_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              baud_clr;
    logic              baud_en;
    logic              baud_tick;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .rd_clk (rd_clk),
        .rst    (rst),
        .clr    (baud_clr),
        .en     (baud_en),
        .tick   (baud_tick)
    );

    // Next-state, pop strobe and serial-bit selection.
    always_comb begin
        state_d      = state_q;
        fifo_rd_d    = 1'b0;
        tx_d         = tx_q;
        frame_done_d = 1'b0;
        frames_d     = frames_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        baud_clr     = 1'b0;
        baud_en      = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = IDLE_LEVEL;
                if (tx_en && !fifo_empty) begin
                    state_d   = REQ;
                    fifo_rd_d = 1'b1;
                end
            end
            REQ: begin
                // The pop is in flight; data appears during LATCH.
                tx_d    = IDLE_LEVEL;
                state_d = LATCH;
            end
            LATCH: begin
                shreg_d   = fifo_data;
                tx_d      = fifo_data[0];
                bit_idx_d = '0;
                baud_clr  = 1'b1;
                state_d   = SHIFT;
            end
            SHIFT: begin
                baud_en = 1'b1;
                if (baud_tick) begin
                    if (bit_idx_q != LAST_IDX) begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                    end else begin
                        // Last bit period ends: chain straight into the next pop if allowed.
                        tx_d         = IDLE_LEVEL;
                        frame_done_d = 1'b1;
                        frames_d     = frames_q + 1'b1;
                        bit_idx_d    = '0;
                        if (tx_en && !fifo_empty) begin
                            state_d   = REQ;
                            fifo_rd_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; reset abandons any frame in progress.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fifo_rd_q    <= 1'b0;
            tx_q         <= IDLE_LEVEL;
            frame_done_q <= 1'b0;
            frames_q     <= '0;
            bit_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            fifo_rd_q    <= fifo_rd_d;
            tx_q         <= tx_d;
            frame_done_q <= frame_done_d;
            frames_q     <= frames_d;
            bit_idx_q    <= bit_idx_d;
        end
    end

    // Shift register holds data only; it is always reloaded in LATCH before use.
    always_ff @(posedge rd_clk) begin
        shreg_q <= shreg_d;
    end

    assign fifo_rd     = fifo_rd_q;
    assign tx          = tx_q;
    assign frame_done  = frame_done_q;
    assign frames_sent = frames_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_frame_serializer.sv
// Self-checking bench for fifo_frame_serializer with a FIFO read-side model
// and a scoreboard of words expected on tx.
module tb_fifo_frame_serializer;

    localparam int DW  = 11;
    localparam int CPB = 4;
    localparam int CW  = 4;

    logic          rd_clk = 1'b0;
    logic          rst    = 1'b1;
    logic          tx_en  = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd;
    logic          tx;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] frames_sent;

    always #5 rd_clk = ~rd_clk;

    fifo_frame_serializer #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB),
        .IDLE_LEVEL   (1'b1),
        .CNT_W        (CW)
    ) dut (
        .rd_clk      (rd_clk),
        .rst         (rst),
        .tx_en       (tx_en),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_rd     (fifo_rd),
        .tx          (tx),
        .busy        (busy),
        .frame_done  (frame_done),
        .frames_sent (frames_sent)
    );

    // FIFO model: words written by the stimulus, read one cycle after fifo_rd.
    logic [DW-1:0] mem [0:63];
    int            wr_idx    = 0;
    int            rd_idx    = 0;
    int            underflow = 0;

    assign fifo_empty = (wr_idx == rd_idx);

    always @(posedge rd_clk) begin
        if (fifo_rd) begin
            if (rd_idx == wr_idx) begin
                underflow <= underflow + 1;
            end else begin
                fifo_data <= mem[rd_idx[5:0]];
                rd_idx    <= rd_idx + 1;
            end
        end
    end

    int rd_cycles = 0;
    int fd_cycles = 0;

    always @(negedge rd_clk) begin
        if (fifo_rd)    rd_cycles <= rd_cycles + 1;
        if (frame_done) fd_cycles <= fd_cycles + 1;
    end

    logic [DW-1:0] exp_q [$];
    int            n_checks   = 0;
    int            n_fail     = 0;
    int            mon_frames = 0;
    int            chain_cnt  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        mem[wr_idx[5:0]] = w;
        wr_idx++;
        exp_q.push_back(w);
    endtask

    task automatic wait_quiet(input int budget, input logic need_empty);
        int n;
        n = 0;
        do begin
            @(negedge rd_clk);
            n++;
        end while (!(!busy && !fifo_rd && (!need_empty || fifo_empty)) && n < budget);
        check_eq("quiet_reached", 32'(n < budget), 1);
        repeat (2) @(negedge rd_clk);
    endtask

    task automatic wait_rd(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge rd_clk);
            n++;
        end while (!fifo_rd && n < budget);
        check_eq("rd_seen", 32'(n < budget), 1);
    endtask

    // Follows one frame starting at the REQ-cycle negedge.
    task automatic mon_frame(output logic chained, output logic aborted);
        logic [DW-1:0] word;
        logic [DW-1:0] want;
        int            glitch;
        word    = '0;
        glitch  = 0;
        chained = 1'b0;
        aborted = 1'b0;
        @(negedge rd_clk);
        if (rst) begin aborted = 1'b1; return; end
        check_eq("latch_tx_idle", 32'(tx), 1);
        check_eq("rd_one_cycle", 32'(fifo_rd), 0);
        check_eq("latch_busy", 32'(busy), 1);
        for (int i = 0; i < DW; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge rd_clk);
                if (rst) begin aborted = 1'b1; return; end
                if (c == 0) word[i] = tx;
                else if (tx !== word[i]) glitch++;
                if (frame_done || fifo_rd || !busy) glitch++;
            end
        end
        @(negedge rd_clk);
        if (rst) begin aborted = 1'b1; return; end
        check_eq("done_pulse", 32'(frame_done), 1);
        check_eq("done_tx_idle", 32'(tx), 1);
        check_eq("bit_glitch", 32'(glitch), 0);
        check_eq("sb_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check_eq("frame_word", 32'(word), 32'(want));
        end
        chained = fifo_rd;
    endtask

    initial begin
        logic ch, ab, go;
        forever begin
            @(negedge rd_clk);
            go = fifo_rd && !rst;
            while (go) begin
                mon_frame(ch, ab);
                if (ab) begin
                    if (exp_q.size() > 0) exp_q.delete(0);
                    go = 1'b0;
                end else begin
                    mon_frames++;
                    if (ch) chain_cnt++;
                    go = ch;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int r0, f0, m0, c0, bad;

        repeat (3) @(negedge rd_clk);
        check_eq("rst_tx", 32'(tx), 1);
        check_eq("rst_fifo_rd", 32'(fifo_rd), 0);
        check_eq("rst_frame_done", 32'(frame_done), 0);
        check_eq("rst_frames_sent", 32'(frames_sent), 0);
        check_eq("rst_busy", 32'(busy), 0);
        #2 rst = 1'b0;
        repeat (2) @(negedge rd_clk);

        // Single word 0x5A3.
        r0 = rd_cycles; f0 = fd_cycles; m0 = mon_frames;
        tx_en = 1'b1;
        push_word(11'h5A3);
        wait_quiet(200, 1'b1);
        check_eq("t1_rd_cycles", 32'(rd_cycles - r0), 1);
        check_eq("t1_done_pulses", 32'(fd_cycles - f0), 1);
        check_eq("t1_frames_seen", 32'(mon_frames - m0), 1);
        check_eq("t1_frames_sent", 32'(frames_sent), 1);
        check_eq("t1_tx_idle", 32'(tx), 1);
        check_eq("t1_busy", 32'(busy), 0);

        // Three preloaded words sent back to back.
        tx_en = 1'b0;
        push_word(11'h001);
        push_word(11'h7FF);
        push_word(11'h2AA);
        r0 = rd_cycles; f0 = fd_cycles; c0 = chain_cnt;
        @(negedge rd_clk);
        tx_en = 1'b1;
        wait_quiet(600, 1'b1);
        repeat (5) @(negedge rd_clk);
        check_eq("t2_rd_cycles", 32'(rd_cycles - r0), 3);
        check_eq("t2_done_pulses", 32'(fd_cycles - f0), 3);
        check_eq("t2_chained", 32'(chain_cnt - c0), 2);
        check_eq("t2_frames_sent", 32'(frames_sent), 4);
        check_eq("t2_underflow", 32'(underflow), 0);

        // Empty FIFO with tx_en held high.
        r0 = rd_cycles; bad = 0;
        repeat (100) begin
            @(negedge rd_clk);
            if (fifo_rd || tx !== 1'b1 || busy) bad++;
        end
        check_eq("t3_idle_violations", 32'(bad), 0);
        check_eq("t3_rd_cycles", 32'(rd_cycles - r0), 0);

        // tx_en dropped mid-frame with a second word queued.
        r0 = rd_cycles;
        push_word(11'h135);
        push_word(11'h4CB);
        wait_rd(20);
        repeat (10) @(negedge rd_clk);
        tx_en = 1'b0;
        wait_quiet(200, 1'b0);
        check_eq("t4_first_rd", 32'(rd_cycles - r0), 1);
        check_eq("t4_frames_sent", 32'(frames_sent), 5);
        repeat (20) @(negedge rd_clk);
        check_eq("t4_no_pop_disabled", 32'(rd_cycles - r0), 1);
        check_eq("t4_idle_busy", 32'(busy), 0);
        tx_en = 1'b1;
        @(negedge rd_clk);
        check_eq("t4_pop_next_edge", 32'(fifo_rd), 1);
        wait_quiet(200, 1'b1);
        check_eq("t4_total_rd", 32'(rd_cycles - r0), 2);
        check_eq("t4_frames_sent2", 32'(frames_sent), 6);

        // Reset asserted in the middle of bit 5.
        r0 = rd_cycles; f0 = fd_cycles;
        push_word(11'h3C5);
        push_word(11'h0F0);
        wait_rd(20);
        repeat (1 + 5 * CPB + 2) @(negedge rd_clk);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_rst_tx", 32'(tx), 1);
        check_eq("t5_rst_busy", 32'(busy), 0);
        check_eq("t5_rst_frames", 32'(frames_sent), 0);
        check_eq("t5_rst_fifo_rd", 32'(fifo_rd), 0);
        repeat (3) @(negedge rd_clk);
        check_eq("t5_no_done_pulse", 32'(fd_cycles - f0), 0);
        #2 rst = 1'b0;
        wait_quiet(300, 1'b1);
        check_eq("t5_rd_cycles", 32'(rd_cycles - r0), 2);
        check_eq("t5_done_pulses", 32'(fd_cycles - f0), 1);
        check_eq("t5_frames_sent", 32'(frames_sent), 1);
        check_eq("t5_underflow", 32'(underflow), 0);

        // frames_sent wrap with a 4-bit counter: 17 frames from zero.
        @(negedge rd_clk);
        #2 rst = 1'b1;
        @(negedge rd_clk);
        #2 rst = 1'b0;
        check_eq("t6_start_zero", 32'(frames_sent), 0);
        for (int k = 0; k < 15; k++) push_word(11'($urandom_range(0, 2047)));
        wait_quiet(15 * 60, 1'b1);
        check_eq("t6_count_f", 32'(frames_sent), 15);
        push_word(11'($urandom_range(0, 2047)));
        wait_quiet(100, 1'b1);
        check_eq("t6_wrap_zero", 32'(frames_sent), 0);
        push_word(11'($urandom_range(0, 2047)));
        wait_quiet(100, 1'b1);
        check_eq("t6_wrap_one", 32'(frames_sent), 1);

        check_eq("sb_leftover", 32'(exp_q.size()), 0);
        check_eq("final_underflow", 32'(underflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_frame_serializer.md
Name: fifo_frame_serializer

Overview:
Downstream consumer of the 11-bit dual-clock FIFO, running entirely in the read clock domain. It pops one word at a time through the FIFO's read-enable/empty interface and shifts each word out LSB-first on a single serial line, holding each bit for a programmable number of rd_clk cycles. Typical use is a UART-style transmitter: each 11-bit word is a pre-built frame (start, 8 data, parity, stop). Status outputs report busy, end of frame and a running frame count.

Parameters:
DATA_W, 11, FIFO word width and serial frame length in bits.
CLKS_PER_BIT, 16, rd_clk cycles per serial bit; legal range is 2 or more.
IDLE_LEVEL, 1'b1, level driven on tx when no frame is being shifted.
CNT_W, 16, width of the frames_sent counter.

Ports:
rd_clk  input  1  block clock; same clock as the FIFO read side.
rst  input  1  asynchronous, active-high reset.
tx_en  input  1  enables the start of new frames; a frame already in progress always completes.
fifo_empty  input  1  FIFO empty flag; already synchronous to rd_clk.
fifo_data  input  DATA_W  FIFO read data; valid on the cycle after fifo_rd is sampled.
fifo_rd  output  1  registered FIFO pop strobe, one cycle wide.
tx  output  1  registered serial output.
busy  output  1  high in the REQ, LATCH and SHIFT states.
frame_done  output  1  one-cycle pulse when the last bit period of a frame ends.
frames_sent  output  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - state=IDLE, tx=IDLE_LEVEL, fifo_rd=0, frame_done=0, frames_sent=0.
  - Baud counter and bit index are cleared.
  - A word already popped or partly shifted is discarded; no extra pop is issued.
- Internal registers:
  - Shift register of DATA_W bits.
  - Baud counter, 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - Bit index, 0..DATA_W-1.
- FSM states:
  - IDLE: tx=IDLE_LEVEL. If tx_en && !fifo_empty, go to REQ and set fifo_rd<=1. Otherwise stay.
  - REQ (1 cycle): fifo_rd is high this cycle and is cleared next edge. Next state is LATCH.
  - LATCH (1 cycle): fifo_data is valid. On the exit edge: shift register <= fifo_data, tx <= fifo_data[0], baud counter=0, bit index=0, next state SHIFT.
  - SHIFT: each cycle, baud counter increments.
    - When the baud counter reaches CLKS_PER_BIT-1 and bit index < DATA_W-1: baud counter=0, bit index++, tx <= next bit (LSB-first).
    - When the baud counter reaches CLKS_PER_BIT-1 and bit index == DATA_W-1: tx <= IDLE_LEVEL, frame_done <= 1 for one cycle, frames_sent++.
    - On that final edge, next state is REQ (with fifo_rd <= 1) if tx_en && !fifo_empty, else IDLE.
- Timing:
  - Latency from fifo_rd high to the first bit on tx is 2 edges.
  - Each bit lasts exactly CLKS_PER_BIT cycles, so a frame lasts DATA_W*CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly 2 cycles at IDLE_LEVEL between them (the REQ and LATCH cycles).
- Boundary conditions:
  - fifo_empty and tx_en are sampled only in IDLE and on the final-bit edge; changes during REQ, LATCH or SHIFT are ignored.
  - fifo_rd is never asserted while fifo_empty=1 was sampled, so no underflow is possible.
  - At most one pop is outstanding at any time.
  - tx_en falling mid-frame: the current frame completes, then the FSM returns to IDLE.
  - frames_sent wraps from 2^CNT_W-1 to 0 without any flag.
  - tx, fifo_rd and frame_done are all flop outputs, so the outputs are glitch-free.

Decomposition:
- Shared package fifo_ser_pkg:
  - State enum with IDLE=2'd0, REQ=2'd1, LATCH=2'd2, SHIFT=2'd3.
  - Constant DEFAULT_CLKS_PER_BIT=16.
  - Constant FRAME_W=11.
- One sub-module, baud_tick_gen: a counter producing a one-cycle tick every CLKS_PER_BIT cycles. It has a synchronous clear, driven from LATCH.
- The FSM and the shift register stay in the top module.

Test Plan:
- Single word, CLKS_PER_BIT=4, FIFO model holding 11'h5A3, tx_en=1:
  - fifo_rd is high for exactly 1 cycle.
  - tx is held for 4 cycles per bit, in the order 1,1,0,0,0,1,0,1,1,0,1.
  - frame_done pulses once; frames_sent=1; tx returns to 1 and the FSM is in IDLE.
- Three words (11'h001, 11'h7FF, 11'h2AA) preloaded:
  - Three frames are sent with exactly 2 idle cycles between frames.
  - fifo_rd fires 3 times; frames_sent=3; no fourth pop after fifo_empty rises.
- fifo_empty=1 with tx_en=1 held for 100 cycles:
  - fifo_rd stays 0, tx stays 1, busy stays 0.
- tx_en deasserted 10 cycles into frame 1 with 2 words queued:
  - Frame 1 completes fully, then IDLE; no second pop until tx_en returns to 1.
  - After tx_en returns, the pop occurs on the next edge.
- rst pulsed in SHIFT at bit index 5:
  - tx=1, busy=0, frames_sent=0 immediately, with no frame_done pulse.
  - After release, the next queued word is popped and sent complete from bit 0.
- CNT_W=4, 17 frames sent:
  - frames_sent reads 1 after wrapping through 0 (0xF→0x0→0x1).
